// File: rtl/gs_pkg.sv
// Shared constants for the Goldschmidt divider datapath: multiplier input FIFO,
// output collector and iteration controller all import this package.
package gs_pkg;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int PROD_W = 2 * MANT_W;

    localparam logic TAG_D = 1'b0;
    localparam logic TAG_N = 1'b1;

endpackage

// File: rtl/gs_round_norm.sv
// Normalizes a 2.46 product in [1,4) to a 1.23 mantissa with round-to-nearest-even.
// Purely combinational; exponent arithmetic wraps modulo 2^EXP_W.
module gs_round_norm
    import gs_pkg::*;
#(
    parameter int MANT_W = gs_pkg::MANT_W,
    parameter int EXP_W  = gs_pkg::EXP_W
) (
    input  logic [2*MANT_W-1:0] prod,
    input  logic [EXP_W-1:0]    exponent,
    output logic [MANT_W-1:0]   m,
    output logic [EXP_W-1:0]    e
);

    logic                w_hi;
    logic [MANT_W-1:0]   w_m_raw;
    logic                w_guard;
    logic                w_sticky;
    logic                w_inc;
    logic [MANT_W:0]     w_sum;
    logic [EXP_W-1:0]    w_e_base;

    assign w_hi     = prod[2*MANT_W-1];
    assign w_m_raw  = w_hi ? prod[2*MANT_W-1:MANT_W] : prod[2*MANT_W-2:MANT_W-1];
    assign w_guard  = w_hi ? prod[MANT_W-1] : prod[MANT_W-2];
    assign w_sticky = w_hi ? (|prod[MANT_W-2:0]) : (|prod[MANT_W-3:0]);
    assign w_e_base = exponent + {{(EXP_W-1){1'b0}}, w_hi};

    assign w_inc = w_guard & (w_sticky | w_m_raw[0]);
    assign w_sum = {1'b0, w_m_raw} + {{MANT_W{1'b0}}, w_inc};

    // A carry out means the mantissa rolled over to 2.0: renormalize to 1.0, bump exponent.
    always_comb begin
        m = w_sum[MANT_W-1:0];
        e = w_e_base;
        if (w_sum[MANT_W]) begin
            m = {1'b1, {(MANT_W-1){1'b0}}};
            e = w_e_base + {{(EXP_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mul_output_collector.sv
// Collects rounded multiplier products into a small first-word-fall-through queue
// drained by the Goldschmidt controller; products arriving while full and stalled are dropped.
module mul_output_collector
    import gs_pkg::*;
#(
    parameter int MANT_W = gs_pkg::MANT_W,
    parameter int EXP_W  = gs_pkg::EXP_W,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     prod_valid,
    input  logic [2*MANT_W-1:0]      prod,
    input  logic                     prod_sign,
    input  logic [EXP_W-1:0]         prod_exponent,
    input  logic                     prod_tag,
    output logic                     prod_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [MANT_W-1:0]        res_mant,
    output logic [MANT_W-1:0]        res_twos,
    output logic                     res_sign,
    output logic [EXP_W-1:0]         res_exponent,
    output logic                     res_tag,
    output logic                     drop,
    output logic                     drop_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [MANT_W-1:0] r_mant [DEPTH];
    logic              r_sign [DEPTH];
    logic [EXP_W-1:0]  r_exp  [DEPTH];
    logic              r_tag  [DEPTH];

    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_drop;
    logic              r_drop_err;

    logic [MANT_W-1:0] w_m;
    logic [EXP_W-1:0]  w_e;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_lost;

    gs_round_norm #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W)
    ) u_round_norm (
        .prod     (prod),
        .exponent (prod_exponent),
        .m        (w_m),
        .e        (w_e)
    );

    assign w_full  = (r_count == FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & res_ready;
    // When full, a simultaneous pop frees the slot being written this cycle.
    assign w_push  = prod_valid & (~w_full | res_ready);
    assign w_lost  = prod_valid & w_full & ~res_ready;

    always_ff @(posedge clk) begin
        if (!clear && w_push) begin
            r_mant[r_wptr] <= w_m;
            r_sign[r_wptr] <= prod_sign;
            r_exp[r_wptr]  <= w_e;
            r_tag[r_wptr]  <= prod_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_drop     <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_drop <= w_lost;
            if (w_lost) r_drop_err <= 1'b1;
        end
    end

    always_comb begin
        res_mant     = '0;
        res_sign     = 1'b0;
        res_exponent = '0;
        res_tag      = 1'b0;
        if (!w_empty) begin
            res_mant     = r_mant[r_rptr];
            res_sign     = r_sign[r_rptr];
            res_exponent = r_exp[r_rptr];
            res_tag      = r_tag[r_rptr];
        end
    end

    assign res_twos   = '0 - res_mant;
    assign res_valid  = ~w_empty;
    assign prod_ready = ~w_full;
    assign count      = r_count;
    assign drop       = r_drop;
    assign drop_err   = r_drop_err;

endmodule

// File: tb/tb_mul_output_collector.sv
// Directed and randomized checks of the product collector against an integer
// rounding model, with a scoreboard of expected queue entries.
module tb_mul_output_collector;
    import gs_pkg::*;

    typedef struct {
        logic [23:0] mant;
        logic        sign;
        logic [7:0]  expo;
        logic        tag;
    } entry_t;

    logic        clk = 1'b0;
    logic        clear;
    logic        prod_valid;
    logic [47:0] prod;
    logic        prod_sign;
    logic [7:0]  prod_exponent;
    logic        prod_tag;
    logic        prod_ready;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] res_mant;
    logic [23:0] res_twos;
    logic        res_sign;
    logic [7:0]  res_exponent;
    logic        res_tag;
    logic        drop;
    logic        drop_err;
    logic [1:0]  count;

    int     vectors     = 0;
    int     miscompares = 0;
    entry_t sb[$];

    mul_output_collector #(
        .MANT_W (24),
        .EXP_W  (8),
        .DEPTH  (2)
    ) dut (
        .clk           (clk),
        .clear         (clear),
        .prod_valid    (prod_valid),
        .prod          (prod),
        .prod_sign     (prod_sign),
        .prod_exponent (prod_exponent),
        .prod_tag      (prod_tag),
        .prod_ready    (prod_ready),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_mant      (res_mant),
        .res_twos      (res_twos),
        .res_sign      (res_sign),
        .res_exponent  (res_exponent),
        .res_tag       (res_tag),
        .drop          (drop),
        .drop_err      (drop_err),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    // Independent integer model: shift, compare remainder to half-ULP, tie to even.
    function automatic entry_t model(input logic [47:0] p, input logic s,
                                     input logic [7:0] ex, input logic t);
        entry_t      r;
        int unsigned sh;
        logic [47:0] q, rem, half;
        sh   = p[47] ? 24 : 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 48'd1 << (sh - 1);
        r.expo = ex + ((sh == 24) ? 8'd1 : 8'd0);
        if (rem > half || (rem == half && q[0])) q = q + 48'd1;
        if (q == 48'h1000000) begin
            q      = 48'h800000;
            r.expo = r.expo + 8'd1;
        end
        r.mant = q[23:0];
        r.sign = s;
        r.tag  = t;
        return r;
    endfunction

    task automatic drive(input logic [47:0] p, input logic s, input logic [7:0] ex, input logic t);
        prod_valid    = 1'b1;
        prod          = p;
        prod_sign     = s;
        prod_exponent = ex;
        prod_tag      = t;
    endtask

    task automatic idle();
        prod_valid = 1'b0;
        prod       = '0;
    endtask

    task automatic check_head(input string tag);
        logic [23:0] twos;
        chk({tag, ".valid"}, {47'd0, res_valid}, 48'd1);
        if (sb.size() > 0) begin
            twos = 24'd0 - sb[0].mant;
            chk({tag, ".mant"}, {24'd0, res_mant}, {24'd0, sb[0].mant});
            chk({tag, ".twos"}, {24'd0, res_twos}, {24'd0, twos});
            chk({tag, ".exp"},  {40'd0, res_exponent}, {40'd0, sb[0].expo});
            chk({tag, ".sign"}, {47'd0, res_sign}, {47'd0, sb[0].sign});
            chk({tag, ".tag"},  {47'd0, res_tag}, {47'd0, sb[0].tag});
        end
    endtask

    task automatic check_empty(input string tag);
        chk({tag, ".count"},  {46'd0, count}, 48'd0);
        chk({tag, ".valid"},  {47'd0, res_valid}, 48'd0);
        chk({tag, ".zeros"},  {res_mant, res_twos}, 48'd0);
        chk({tag, ".zflags"}, {38'd0, res_exponent, res_sign, res_tag}, 48'd0);
        chk({tag, ".ready"},  {47'd0, prod_ready}, 48'd1);
    endtask

    // One product in, check head, drain it, check empty.
    task automatic single(input string tag, input logic [47:0] p, input logic s,
                          input logic [7:0] ex, input logic t);
        drive(p, s, ex, t);
        sb.push_back(model(p, s, ex, t));
        step();
        idle();
        check_head(tag);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        void'(sb.pop_front());
        check_empty({tag, ".drain"});
    endtask

    initial begin
        entry_t      e;
        logic [47:0] p;

        clear     = 1'b1;
        res_ready = 1'b0;
        drive(48'h400000_000000, 1'b0, 8'h7F, TAG_D);
        step();
        step();
        idle();
        check_empty("reset");
        chk("reset.drop", {46'd0, drop, drop_err}, 48'd0);
        clear = 1'b0;
        step();
        check_empty("post_reset");

        // Directed boundary products with hand-derived results
        drive(48'h400000_000000, 1'b0, 8'h7F, TAG_D);
        e = '{mant: 24'h800000, sign: 1'b0, expo: 8'h7F, tag: TAG_D};
        sb.push_back(e);
        step(); idle();
        check_head("one");
        res_ready = 1'b1; step(); res_ready = 1'b0; void'(sb.pop_front());

        drive(48'h800000_000000, 1'b1, 8'h7F, TAG_N);
        e = '{mant: 24'h800000, sign: 1'b1, expo: 8'h80, tag: TAG_N};
        sb.push_back(e);
        step(); idle();
        check_head("upper");
        res_ready = 1'b1; step(); res_ready = 1'b0; void'(sb.pop_front());

        drive(48'h800000_000000, 1'b0, 8'hFF, TAG_D);
        e = '{mant: 24'h800000, sign: 1'b0, expo: 8'h00, tag: TAG_D};
        sb.push_back(e);
        step(); idle();
        check_head("exp_wrap");
        res_ready = 1'b1; step(); res_ready = 1'b0; void'(sb.pop_front());

        drive(48'h400001_400000, 1'b0, 8'h20, TAG_D);
        e = '{mant: 24'h800002, sign: 1'b0, expo: 8'h20, tag: TAG_D};
        sb.push_back(e);
        step(); idle();
        check_head("tie_even");
        res_ready = 1'b1; step(); res_ready = 1'b0; void'(sb.pop_front());

        drive(48'h400001_C00000, 1'b0, 8'h20, TAG_N);
        e = '{mant: 24'h800004, sign: 1'b0, expo: 8'h20, tag: TAG_N};
        sb.push_back(e);
        step(); idle();
        check_head("tie_odd");
        res_ready = 1'b1; step(); res_ready = 1'b0; void'(sb.pop_front());

        drive(48'h7FFFFF_C00000, 1'b0, 8'h10, TAG_D);
        e = '{mant: 24'h800000, sign: 1'b0, expo: 8'h11, tag: TAG_D};
        sb.push_back(e);
        step(); idle();
        check_head("carry");
        res_ready = 1'b1; step(); res_ready = 1'b0; void'(sb.pop_front());
        check_empty("directed_drain");

        // Randomized products through the reference model
        for (int i = 0; i < 8; i++) begin
            p = {$urandom, $urandom};
            if (p[47:46] == 2'b00) p[46] = 1'b1;
            single($sformatf("rand%0d", i), p, 1'($urandom), 8'($urandom), 1'($urandom));
        end

        // Fill, overflow and drop
        res_ready = 1'b0;
        drive(48'h500000_000000, 1'b0, 8'h01, TAG_D);
        sb.push_back(model(48'h500000_000000, 1'b0, 8'h01, TAG_D));
        step();
        chk("fill1.count", {46'd0, count}, 48'd1);
        drive(48'hA00000_800001, 1'b1, 8'h02, TAG_N);
        sb.push_back(model(48'hA00000_800001, 1'b1, 8'h02, TAG_N));
        step();
        chk("fill2.count", {46'd0, count}, 48'd2);
        chk("fill2.ready", {47'd0, prod_ready}, 48'd0);
        chk("fill2.drop",  {46'd0, drop, drop_err}, 48'd0);
        check_head("fill2.head");
        drive(48'h600000_000000, 1'b0, 8'h03, TAG_D);
        step();
        chk("lost.drop",  {46'd0, drop, drop_err}, 48'd3);
        chk("lost.count", {46'd0, count}, 48'd2);
        check_head("lost.head");
        drive(48'h700000_000001, 1'b0, 8'h04, TAG_N);
        sb.push_back(model(48'h700000_000001, 1'b0, 8'h04, TAG_N));
        res_ready = 1'b1;
        step();
        void'(sb.pop_front());
        res_ready = 1'b0;
        idle();
        chk("pushpop.drop",  {46'd0, drop, drop_err}, 48'd1);
        chk("pushpop.count", {46'd0, count}, 48'd2);
        check_head("pushpop.head");
        res_ready = 1'b1;
        step();
        void'(sb.pop_front());
        res_ready = 1'b0;
        chk("wrap.count", {46'd0, count}, 48'd1);
        check_head("wrap.head");

        // Refill to full, then clear with a concurrent product and pop
        drive(48'h480000_000000, 1'b1, 8'h05, TAG_D);
        sb.push_back(model(48'h480000_000000, 1'b1, 8'h05, TAG_D));
        step();
        chk("refill.count", {46'd0, count}, 48'd2);
        clear = 1'b1;
        res_ready = 1'b1;
        drive(48'h900000_000000, 1'b0, 8'h06, TAG_N);
        step();
        clear = 1'b0;
        res_ready = 1'b0;
        idle();
        sb.delete();
        check_empty("clear");
        chk("clear.drop", {46'd0, drop, drop_err}, 48'd0);
        step();
        chk("clear.hold", {46'd0, count}, 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_output_collector.md
# mul_output_collector

Receiving end of the pipelined array multiplier in the Goldschmidt divider. Each cycle it may capture one 48-bit raw product plus its sign and exponent from the last multiplier stage. It normalizes and rounds the product to a 24-bit 1.23 mantissa and buffers it in a 2-entry first-word-fall-through queue. The Goldschmidt iteration controller drains the queue over a valid/ready handshake, receiving the rounded mantissa and its two's complement (the next correction factor, F = 2 − D).

## Interface
- MANT_W, 24, mantissa width (1.23 fixed point)
- EXP_W, 8, exponent width
- DEPTH, 2, queue depth, power of two
- clk  in  1  clock, all logic on rising edge
- clear  in  1  synchronous active-high reset
- prod_valid  in  1  last multiplier stage holds a valid product; the multiplier cannot stall
- prod  in  2*MANT_W  unsigned product of two 1.23 operands, 2.46 format, value in [1,4)
- prod_sign  in  1  sign carried down the pipeline
- prod_exponent  in  EXP_W  exponent carried down the pipeline
- prod_tag  in  1  0 = D path, 1 = N path
- prod_ready  out  1  advisory, count < DEPTH
- res_valid  out  1  queue non-empty
- res_ready  in  1  consumer accepts head entry
- res_mant  out  MANT_W  head normalized, rounded mantissa
- res_twos  out  MANT_W  (2^MANT_W − res_mant) mod 2^MANT_W
- res_sign  out  1  head sign
- res_exponent  out  EXP_W  head adjusted exponent
- res_tag  out  1  head tag
- drop  out  1  one-cycle pulse: a product was lost
- drop_err  out  1  sticky drop flag, cleared only by clear
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Normalize, combinational on prod:
  - If prod[47]=1: m = prod[47:24], guard = prod[23], sticky = |prod[22:0], e = prod_exponent + 1.
  - Else: m = prod[46:23], guard = prod[22], sticky = |prod[21:0], e = prod_exponent.
- Round to nearest even: increment m when guard & (sticky | m[0]).
  - If the increment carries out of m (m was all ones), m = 24'h800000 and e increments once more.
- Exponent arithmetic wraps modulo 2^EXP_W. No saturation or flag; range is checked upstream.
- Sign and tag pass through unchanged.
- push = prod_valid & (count < DEPTH | res_ready). pop = res_valid & res_ready.
- drop = prod_valid & count == DEPTH & ~res_ready. The product is discarded, drop pulses and drop_err sets.
- Simultaneous push and pop: allowed at any occupancy, including full. count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Outputs res_mant, res_twos, res_sign, res_exponent and res_tag read the head entry and are forced to 0 while count == 0.
- res_twos is combinational from res_mant.

## Timing
- Latency: prod_valid at edge t → entry visible on res_* with res_valid=1 after edge t (same cycle as the write). Sampled product is registered at edge t.
- res_valid, count and prod_ready are functions of registered state only. There is no combinational path from res_ready to prod_ready.
- Reset values (clear sampled high): count 0, pointers 0, res_valid 0, all res_* 0, drop 0, drop_err 0, prod_ready 1.
- clear mid-operation: all queued entries and any product presented in the same cycle are discarded. clear has priority over push, pop and drop.
- drop is registered, asserted the cycle after the lost product.

## Structure
- Shared package gs_pkg: MANT_W, EXP_W, PROD_W = 2*MANT_W, tag constants TAG_D = 0 and TAG_N = 1. The existing multiplier input FIFO and the controller share the same package.
- Sub-module gs_round_norm: combinational normalize and round, with outputs m and e. It is instantiated once and is reusable by the controller.
- Queue storage: register arrays of depth DEPTH for mantissa, sign, exponent and tag.

## Test plan
- Reset: hold clear 2 cycles with prod_valid=1 → count=0, res_valid=0, all res_* = 0, prod_ready=1, drop_err=0.
- Exact 1.0: prod=48'h400000_000000, exp 8'h7F, tag 0 → res_mant=24'h800000, res_twos=24'h800000, res_exponent=8'h7F, res_tag=0.
- Upper-bit normalize: prod=48'h800000_000000, exp 8'h7F → res_mant=24'h800000, res_exponent=8'h80. With exp 8'hFF → res_exponent=8'h00 (wrap).
- Rounding:
  - Tie to even: prod=48'h400001_400000 → res_mant=24'h800002.
  - Tie, odd LSB: prod=48'h400001_C00000 → res_mant=24'h800004.
  - Carry-out: prod=48'h7FFFFF_C00000, exp 8'h10 → res_mant=24'h800000, res_exponent=8'h11.
- Full and drop:
  - res_ready=0, three back-to-back valid products → first two queued, count=2, prod_ready=0; third lost, drop pulses one cycle, drop_err stays 1.
  - Next cycle, prod_valid=1 with res_ready=1 → accepted, count stays 2, head advances to the second entry.
- Mid-operation clear: count=2, assert clear with prod_valid=1 and res_ready=1 → next cycle count=0, res_valid=0, drop_err=0. The new product is not stored.
